// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants, transmitter state encoding and
// a baud-divider helper reused by the transmitter and a future receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        CLEANUP = 3'd4
    } uart_tx_state_t;

    localparam int   DATA_BITS   = 8;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;
    localparam logic IDLE_LEVEL  = 1'b1;

    // Truncating divide: the bit period is the whole number of clocks per bit.
    function automatic int calc_clks_per_bit(input longint clk_hz, input longint baud);
        return int'(clk_hz / baud);
    endfunction

endpackage

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: one start bit, eight data bits LSB first, one stop bit,
// each CLKS_PER_BIT clocks long. All outputs come straight from flops.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = calc_clks_per_bit(100_000_000, 115_200)
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_TX_DV,
    input  logic [7:0] i_TX_Byte,
    output logic       o_TX_Active,
    output logic       o_TX_Serial,
    output logic       o_TX_Done
);

    localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        LAST_BIT = 3'(DATA_BITS - 1);

    uart_tx_state_t   state_q, state_d;
    logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       byte_q, byte_d;
    logic             serial_q, serial_d;
    logic             active_q, active_d;
    logic             done_q, done_d;
    logic             bit_end;

    assign bit_end = (clk_cnt_q == CNT_MAX);

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_idx_d = bit_idx_q;
        byte_d    = byte_q;
        serial_d  = serial_q;
        active_d  = active_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                serial_d  = IDLE_LEVEL;
                active_d  = 1'b0;
                clk_cnt_d = '0;
                bit_idx_d = '0;
                if (i_TX_DV) begin
                    byte_d   = i_TX_Byte;
                    serial_d = START_LEVEL;
                    active_d = 1'b1;
                    state_d  = START;
                end
            end
            START: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    serial_d  = byte_q[0];
                    state_d   = DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    if (bit_idx_q == LAST_BIT) begin
                        bit_idx_d = '0;
                        serial_d  = STOP_LEVEL;
                        state_d   = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        serial_d  = byte_q[bit_idx_q + 3'd1];
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    done_d    = 1'b1;
                    active_d  = 1'b0;
                    state_d   = CLEANUP;
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            CLEANUP: begin
                state_d = IDLE;
            end
            default: begin
                state_d  = IDLE;
                serial_d = IDLE_LEVEL;
                active_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_q   <= IDLE;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            byte_q    <= '0;
            serial_q  <= IDLE_LEVEL;
            active_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_idx_q <= bit_idx_d;
            byte_q    <= byte_d;
            serial_q  <= serial_d;
            active_q  <= active_d;
            done_q    <= done_d;
        end
    end

    assign o_TX_Serial = serial_q;
    assign o_TX_Active = active_q;
    assign o_TX_Done   = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus queues expected bytes, a per-instance
// line monitor decodes frames, checks bit timing and handshake, and compares.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst4 = 1'b0, rst8 = 1'b0;
    logic       dv4 = 1'b0, dv8 = 1'b0;
    logic [7:0] byte4 = 8'h00, byte8 = 8'h00;
    logic       s4, a4, d4, s8, a8, d8;

    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         n_done4 = 0, n_done8 = 0;
    logic [7:0] exp_q4[$];
    logic [7:0] exp_q8[$];
    int         starts4[$];

    uart_tx #(.CLKS_PER_BIT(4)) dut4 (
        .i_Clock(clk), .i_Reset(rst4), .i_TX_DV(dv4), .i_TX_Byte(byte4),
        .o_TX_Active(a4), .o_TX_Serial(s4), .o_TX_Done(d4)
    );

    uart_tx dut868 (
        .i_Clock(clk), .i_Reset(rst8), .i_TX_DV(dv8), .i_TX_Byte(byte8),
        .o_TX_Active(a8), .o_TX_Serial(s8), .o_TX_Done(d8)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (d4 === 1'b1) n_done4 <= n_done4 + 1;
        if (d8 === 1'b1) n_done8 <= n_done8 + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic get_s(input bit sel);   return sel ? s8 : s4;     endfunction
    function automatic logic get_a(input bit sel);   return sel ? a8 : a4;     endfunction
    function automatic logic get_d(input bit sel);   return sel ? d8 : d4;     endfunction
    function automatic logic get_rst(input bit sel); return sel ? rst8 : rst4; endfunction

    task automatic monitor(input bit sel, input int cpb);
        logic [7:0] rx;
        logic [7:0] expb;
        logic       s;
        bit         ok;
        bit         aborted;
        int         start;
        int         bitpos;
        forever begin
            @(negedge clk);
            if (get_rst(sel) === 1'b0 && get_s(sel) === 1'b0) begin
                start   = cyc;
                ok      = 1'b1;
                aborted = 1'b0;
                rx      = 8'h00;
                for (int i = 0; i < 10 * cpb; i++) begin
                    if (i > 0) @(negedge clk);
                    if (get_rst(sel) !== 1'b0) begin
                        aborted = 1'b1;
                        break;
                    end
                    s      = get_s(sel);
                    bitpos = i / cpb;
                    if (get_a(sel) !== 1'b1 || get_d(sel) !== 1'b0) ok = 1'b0;
                    if (bitpos == 0) begin
                        if (s !== 1'b0) ok = 1'b0;
                    end else if (bitpos == 9) begin
                        if (s !== 1'b1) ok = 1'b0;
                    end else if (i % cpb == 0) begin
                        rx[bitpos-1] = s;
                    end else if (s !== rx[bitpos-1]) begin
                        ok = 1'b0;
                    end
                end
                if (!aborted) begin
                    check(sel ? "frame_timing_868" : "frame_timing_4", 32'(ok), 32'd1);
                    @(negedge clk);
                    check("done_edge", {29'd0, get_d(sel), get_a(sel), get_s(sel)}, 32'b101);
                    @(negedge clk);
                    check("cleanup_edge", {29'd0, get_d(sel), get_a(sel), get_s(sel)}, 32'b001);
                    if (!sel) starts4.push_back(start);
                    if ((sel ? exp_q8.size() : exp_q4.size()) == 0) begin
                        check("unexpected_frame", 32'(rx), 32'hFFFF_FFFF);
                    end else begin
                        expb = sel ? exp_q8.pop_front() : exp_q4.pop_front();
                        $display("frame dut%0d: rx=0x%02h exp=0x%02h start_cycle=%0d",
                                 sel ? 868 : 4, rx, expb, start);
                        check("rx_byte", 32'(rx), 32'(expb));
                    end
                end
            end
        end
    endtask

    initial monitor(1'b0, 4);
    initial monitor(1'b1, 868);

    task automatic send4(input logic [7:0] b, input int wait_cycles);
        exp_q4.push_back(b);
        byte4 = b;
        dv4   = 1'b1;
        @(posedge clk);
        #1 dv4 = 1'b0;
        repeat (wait_cycles) @(posedge clk);
        #1;
    endtask

    int nd_before;

    initial begin
        // Asynchronous reset before any clock edge.
        #2 rst4 = 1'b1; rst8 = 1'b1;
        #1;
        check("reset_serial", 32'(s4), 32'd1);
        check("reset_active", 32'(a4), 32'd0);
        check("reset_done",   32'(d4), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst4 = 1'b0; rst8 = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        send4(8'hA5, 48);

        // DV held high across two frames; second must start 42 clocks later.
        exp_q4.push_back(8'h00);
        exp_q4.push_back(8'hFF);
        byte4 = 8'h00;
        dv4   = 1'b1;
        @(posedge clk);
        #1 byte4 = 8'hFF;
        repeat (43) @(posedge clk);
        #1 dv4 = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        if (starts4.size() >= 3)
            check("b2b_gap", 32'(starts4[$] - starts4[$-1]), 32'd42);
        else
            check("b2b_frames", 32'(starts4.size()), 32'd3);

        // Byte input changes right after the accept edge.
        exp_q4.push_back(8'h3C);
        byte4 = 8'h3C;
        dv4   = 1'b1;
        @(posedge clk);
        #1 dv4 = 1'b0;
        byte4 = 8'hC3;
        repeat (48) @(posedge clk);
        #1;

        // Reset during data bit 3 of 0x55 (bit 3 is 0).
        byte4 = 8'h55;
        dv4   = 1'b1;
        @(posedge clk);
        #1 dv4 = 1'b0;
        repeat (17) @(posedge clk);
        #1;
        check("pre_reset_bit3", 32'(s4), 32'd0);
        nd_before = n_done4;
        rst4 = 1'b1;
        #1;
        check("midframe_reset_serial", 32'(s4), 32'd1);
        check("midframe_reset_active", 32'(a4), 32'd0);
        check("midframe_reset_done",   32'(d4), 32'd0);
        repeat (5) @(posedge clk);
        #1 rst4 = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        check("no_done_on_abort", 32'(n_done4), 32'(nd_before));

        send4(8'h81, 48);

        // Default divider: 868 clocks per bit.
        exp_q8.push_back(8'h41);
        byte8 = 8'h41;
        dv8   = 1'b1;
        @(posedge clk);
        #1 dv8 = 1'b0;
        repeat (8700) @(posedge clk);
        #1;

        check("pending_frames_4",   32'(exp_q4.size()), 32'd0);
        check("pending_frames_868", 32'(exp_q8.size()), 32'd0);
        check("done_pulses_4",      32'(n_done4), 32'd5);
        check("done_pulses_868",    32'(n_done8), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
